tile_output_writer: RTL and testbench

Drains a complete output tile of the processing array to memory: up to N vectors (rows or columns) of N elements each, written P elements per memory beat at a programmable row stride. It sits between the array's `c_data_streaming` port and the memory write port, and takes instructions from the controller. It generalises the single-vector output writer with three additions: a multi-slot vector FIFO so the array can stream while memory drains, strided multi-vector addressing, and a programmable vector count.

---
 rtl/tile_output_writer.sv | 160 ++++++++++++++++
 tb/tb_tile_output_writer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_output_writer.sv
// Streams an NxN output tile from the array into a BUFFER_DEPTH-slot vector FIFO and drains it
// to memory P elements per beat at base + vi*stride + bi*P; write side stalls hold address/data.
module tile_output_writer #(
  parameter int OUTPUT_DATA_WIDTH            = 8,
  parameter int N                            = 4,
  parameter int MEMORY_ADDRESS_BITS          = 64,
  parameter int PARALLEL_DATA_STREAMING_SIZE = 4,
  parameter int BUFFER_DEPTH                 = 2,
  parameter int STRIDE_BITS                  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           instruction_valid,
  output logic                           instruction_ready,
  input  logic [MEMORY_ADDRESS_BITS-1:0] address_input,
  input  logic [STRIDE_BITS-1:0]         stride_input,
  input  logic [$clog2(N+1)-1:0]         vector_count_input,
  input  logic                           output_by_row_instruction,
  output logic                           completed_valid,
  input  logic                           completed_ready,
  output logic                           write_valid,
  input  logic                           write_ready,
  output logic [MEMORY_ADDRESS_BITS-1:0] write_address,
  output logic [OUTPUT_DATA_WIDTH-1:0]   write_data [PARALLEL_DATA_STREAMING_SIZE],
  input  logic                           output_valid,
  output logic                           output_ready,
  output logic                           output_by_row,
  input  logic [OUTPUT_DATA_WIDTH-1:0]   c_data_streaming [N]
);
  localparam int P  = PARALLEL_DATA_STREAMING_SIZE;
  localparam int NB = N / P;
  localparam int AW = MEMORY_ADDRESS_BITS;
  localparam int CW = $clog2(N + 1);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int OW = $clog2(BUFFER_DEPTH + 1);

  generate
    if (P < 1 || (N % P) != 0) begin : g_bad_beat
      $error("PARALLEL_DATA_STREAMING_SIZE must divide N");
    end
    if (BUFFER_DEPTH < 1 || (BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("BUFFER_DEPTH must be a power of two and at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                         r_state;
  logic [AW-1:0]                  r_base;
  logic [STRIDE_BITS-1:0]         r_stride;
  logic [CW-1:0]                  r_count;
  logic                           r_mode;
  logic [CW-1:0]                  r_acc;
  logic [CW-1:0]                  r_vi;
  logic [BW-1:0]                  r_bi;
  logic [PW-1:0]                  r_head;
  logic [PW-1:0]                  r_tail;
  logic [OW-1:0]                  r_occ;
  logic [OUTPUT_DATA_WIDTH-1:0]   r_fifo [BUFFER_DEPTH][N];

  logic          w_ordy;
  logic          w_wvld;
  logic          w_push;
  logic          w_wfire;
  logic          w_last_beat;
  logic          w_pop;
  logic [AW-1:0] w_addr;

  // Ready/valid depend only on registered state, never on the partner's handshake input.
  assign w_ordy      = (r_state == ACTIVE) && (r_occ < OW'(BUFFER_DEPTH)) && (r_acc < r_count);
  assign w_wvld      = (r_state == ACTIVE) && (r_occ != '0);
  assign w_push      = w_ordy && output_valid;
  assign w_wfire     = w_wvld && write_ready;
  assign w_last_beat = (r_bi == BW'(NB - 1));
  assign w_pop       = w_wfire && w_last_beat;

  assign w_addr = r_base + AW'(r_vi) * AW'(r_stride) + AW'(r_bi) * AW'(P);

  assign instruction_ready = (r_state == IDLE);
  assign completed_valid   = (r_state == DONE);
  assign output_ready      = w_ordy;
  assign write_valid       = w_wvld;
  assign output_by_row     = r_mode;
  assign write_address     = w_wvld ? w_addr : '0;

  always_comb begin
    for (int i = 0; i < P; i++) write_data[i] = '0;
    if (w_wvld) begin
      for (int b = 0; b < NB; b++) begin
        if (r_bi == BW'(b)) begin
          for (int i = 0; i < P; i++) write_data[i] = r_fifo[r_head][b*P + i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_base   <= '0;
      r_stride <= '0;
      r_count  <= '0;
      r_mode   <= 1'b0;
      r_acc    <= '0;
      r_vi     <= '0;
      r_bi     <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_occ    <= '0;
      r_fifo   <= '{default: '{default: '0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (instruction_valid) begin
            r_base   <= address_input;
            r_stride <= stride_input;
            r_count  <= vector_count_input;
            r_mode   <= output_by_row_instruction;
            r_acc    <= '0;
            r_vi     <= '0;
            r_bi     <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_occ    <= '0;
            r_state  <= (vector_count_input == '0) ? DONE : ACTIVE;
          end
        end
        ACTIVE: begin
          if (w_push) begin
            r_fifo[r_tail] <= c_data_streaming;
            r_tail         <= (r_tail == PW'(BUFFER_DEPTH - 1)) ? '0 : r_tail + 1'b1;
            r_acc          <= r_acc + 1'b1;
          end
          if (w_wfire) begin
            if (w_last_beat) begin
              r_bi   <= '0;
              r_head <= (r_head == PW'(BUFFER_DEPTH - 1)) ? '0 : r_head + 1'b1;
              r_vi   <= r_vi + 1'b1;
              if (r_vi == r_count - CW'(1)) r_state <= DONE;
            end else begin
              r_bi <= r_bi + 1'b1;
            end
          end
          // A pop frees its slot only from the next cycle on.
          case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
          endcase
        end
        DONE: begin
          if (completed_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_output_writer.sv
// Directed bench for tile_output_writer (N=4, P=2, DEPTH=2); a second instance with
// 8-bit addresses covers address wrap-around.
module tb_tile_output_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, iv, iv8, cr, wr, ov, mode, sel;
  logic [63:0] addr;
  logic [7:0]  addr8;
  logic [15:0] stride;
  logic [2:0]  cnt;
  logic [7:0]  cdat [4];

  logic        irdy, cvld, wvld, ordy, obr;
  logic [63:0] waddr;
  logic [7:0]  wdat [2];
  logic        irdy8, cvld8, wvld8, ordy8, obr8;
  logic [7:0]  waddr8;
  logic [7:0]  wdat8 [2];

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_a [8];

  tile_output_writer #(
    .OUTPUT_DATA_WIDTH(8), .N(4), .MEMORY_ADDRESS_BITS(64),
    .PARALLEL_DATA_STREAMING_SIZE(2), .BUFFER_DEPTH(2), .STRIDE_BITS(16)
  ) u_dut (
    .clk(clk), .reset(reset),
    .instruction_valid(iv), .instruction_ready(irdy),
    .address_input(addr), .stride_input(stride), .vector_count_input(cnt),
    .output_by_row_instruction(mode),
    .completed_valid(cvld), .completed_ready(cr),
    .write_valid(wvld), .write_ready(wr), .write_address(waddr), .write_data(wdat),
    .output_valid(ov), .output_ready(ordy), .output_by_row(obr),
    .c_data_streaming(cdat)
  );

  tile_output_writer #(
    .OUTPUT_DATA_WIDTH(8), .N(4), .MEMORY_ADDRESS_BITS(8),
    .PARALLEL_DATA_STREAMING_SIZE(2), .BUFFER_DEPTH(2), .STRIDE_BITS(16)
  ) u_dut8 (
    .clk(clk), .reset(reset),
    .instruction_valid(iv8), .instruction_ready(irdy8),
    .address_input(addr8), .stride_input(stride), .vector_count_input(cnt),
    .output_by_row_instruction(mode),
    .completed_valid(cvld8), .completed_ready(cr),
    .write_valid(wvld8), .write_ready(wr), .write_address(waddr8), .write_data(wdat8),
    .output_valid(ov), .output_ready(ordy8), .output_by_row(obr8),
    .c_data_streaming(cdat)
  );

  logic        m_wvld, m_ordy, m_cvld, m_irdy;
  logic [63:0] m_waddr;
  logic [7:0]  m_d0, m_d1;
  assign m_wvld  = sel ? wvld8  : wvld;
  assign m_ordy  = sel ? ordy8  : ordy;
  assign m_cvld  = sel ? cvld8  : cvld;
  assign m_irdy  = sel ? irdy8  : irdy;
  assign m_waddr = sel ? {56'd0, waddr8} : waddr;
  assign m_d0    = sel ? wdat8[0] : wdat[0];
  assign m_d1    = sel ? wdat8[1] : wdat[1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_irdy"}, 64'(irdy), 64'd1);
    chk({tag, "_cvld"}, 64'(cvld), 64'd0);
    chk({tag, "_wvld"}, 64'(wvld), 64'd0);
    chk({tag, "_waddr"}, waddr, 64'd0);
    chk({tag, "_wd0"}, 64'(wdat[0]), 64'd0);
    chk({tag, "_wd1"}, 64'(wdat[1]), 64'd0);
    chk({tag, "_ordy"}, 64'(ordy), 64'd0);
    chk({tag, "_obr"}, 64'(obr), 64'd0);
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic issue(input logic s, input logic [63:0] base, input logic [15:0] strd,
                       input logic [2:0] n, input logic m);
    sel = s; addr = base; addr8 = base[7:0]; stride = strd; cnt = n; mode = m;
    if (s) iv8 = 1'b1; else iv = 1'b1;
    chk("ins_rdy", 64'(s ? irdy8 : irdy), 64'd1);
    @(negedge clk);
    iv = 1'b0; iv8 = 1'b0;
  endtask

  // Vectors carry 1..16 in order, so write beat k must carry {2k+1, 2k+2}.
  task automatic run_stream(input int nvec, input int nwr, input int bp_at, input int bp_len,
                            input int budget);
    int sent = 0, got = 0, cyc = 0, stall = 0, first_acc = -1, first_wr = -1;
    logic [63:0] ha;
    logic [7:0]  hd0, hd1;
    ha = '0; hd0 = '0; hd1 = '0;
    while (got < nwr && cyc < budget) begin
      if (m_wvld && got == bp_at && stall < bp_len) begin
        wr = 1'b0;
        if (stall == 0) begin
          ha = m_waddr; hd0 = m_d0; hd1 = m_d1;
        end else begin
          chk("hold_addr", m_waddr, ha);
          chk("hold_d0", 64'(m_d0), 64'(hd0));
          chk("hold_d1", 64'(m_d1), 64'(hd1));
        end
        if (stall == bp_len - 1) chk("full_ordy", 64'(m_ordy), 64'd0);
        stall++;
      end else begin
        wr = 1'b1;
        if (m_wvld) begin
          if (got == 0) first_wr = cyc;
          chk("wr_addr", m_waddr, exp_a[got]);
          chk("wr_d0", 64'(m_d0), 64'(2*got + 1));
          chk("wr_d1", 64'(m_d1), 64'(2*got + 2));
          got++;
        end
      end
      if (sent < nvec) begin
        ov = 1'b1;
        for (int e = 0; e < 4; e++) cdat[e] = 8'(4*sent + e + 1);
        if (m_ordy) begin
          if (sent == 0) first_acc = cyc;
          sent++;
        end
      end else begin
        ov = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    ov = 1'b0;
    wr = 1'b1;
    chk("stream_writes", 64'(got), 64'(nwr));
    if (first_wr >= 0) chk("first_wr_lat", 64'(first_wr - first_acc), 64'd1);
  endtask

  task automatic finish_done();
    cr = 1'b1;
    @(negedge clk);
    cr = 1'b0;
    chk("irdy_after_done", 64'(m_irdy), 64'd1);
    chk("cvld_after_done", 64'(m_cvld), 64'd0);
  endtask

  initial begin
    reset = 1'b1; iv = 1'b0; iv8 = 1'b0; cr = 1'b0; wr = 1'b1; ov = 1'b0; mode = 1'b0; sel = 1'b0;
    addr = '0; addr8 = '0; stride = '0; cnt = '0;
    for (int e = 0; e < 4; e++) cdat[e] = '0;
    repeat (3) @(negedge clk);
    check_reset_outs("rst");
    reset = 1'b0;
    @(negedge clk);

    // Basic tile
    exp_a = '{64'h100, 64'h102, 64'h108, 64'h10A, 64'h110, 64'h112, 64'h118, 64'h11A};
    issue(1'b0, 64'h100, 16'd8, 3'd4, 1'b1);
    chk("ordy_after_ins", 64'(ordy), 64'd1);
    chk("by_row", 64'(obr), 64'd1);
    run_stream(4, 8, -1, 0, 200);
    chk("cvld_basic", 64'(cvld), 64'd1);
    chk("wvld_in_done", 64'(wvld), 64'd0);
    finish_done();

    // Backpressure: stall the second beat for 5 cycles
    exp_a = '{64'h200, 64'h202, 64'h204, 64'h206, 64'h208, 64'h20A, 64'h20C, 64'h20E};
    issue(1'b0, 64'h200, 16'd4, 3'd4, 1'b1);
    run_stream(4, 8, 1, 5, 200);
    chk("cvld_bp", 64'(cvld), 64'd1);
    finish_done();

    // Count 1 then completion hold
    exp_a = '{64'h500, 64'h502, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    issue(1'b0, 64'h500, 16'd8, 3'd1, 1'b1);
    run_stream(1, 2, -1, 0, 100);
    for (int k = 0; k < 10; k++) begin
      chk("hold_cvld", 64'(cvld), 64'd1);
      chk("hold_irdy", 64'(irdy), 64'd0);
      chk("hold_wvld", 64'(wvld), 64'd0);
      @(negedge clk);
    end
    finish_done();

    // Count 0, column mode
    issue(1'b0, 64'h600, 16'd8, 3'd0, 1'b0);
    chk("cnt0_cvld", 64'(cvld), 64'd1);
    chk("cnt0_wvld", 64'(wvld), 64'd0);
    chk("cnt0_ordy", 64'(ordy), 64'd0);
    chk("col_mode", 64'(obr), 64'd0);
    finish_done();

    // Address wrap on the 8-bit instance
    exp_a = '{64'hFE, 64'h00, 64'h02, 64'h04, 64'h0, 64'h0, 64'h0, 64'h0};
    issue(1'b1, 64'hFE, 16'd4, 3'd2, 1'b1);
    run_stream(2, 4, -1, 0, 100);
    chk("cvld_wrap", 64'(cvld8), 64'd1);
    finish_done();
    sel = 1'b0;
    @(negedge clk);

    // Reset after 3 beats
    exp_a = '{64'h300, 64'h302, 64'h308, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    issue(1'b0, 64'h300, 16'd8, 3'd4, 1'b1);
    run_stream(4, 3, -1, 0, 100);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outs("mid_rst");
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_wvld", 64'(wvld), 64'd0);
      chk("post_rst_cvld", 64'(cvld), 64'd0);
    end
    exp_a = '{64'h100, 64'h102, 64'h108, 64'h10A, 64'h110, 64'h112, 64'h118, 64'h11A};
    issue(1'b0, 64'h100, 16'd8, 3'd4, 1'b1);
    run_stream(4, 8, -1, 0, 200);
    chk("cvld_after_rst", 64'(cvld), 64'd1);
    finish_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
